// File: rtl/seq_shifter_pkg.sv
// ============================================================================
// Module  : seq_shifter_pkg
// Brief   : Shared mode codes and FSM state encoding for the sequential shifter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_shifter_pkg;

    localparam logic [1:0] C_MODE_SLL = 2'b00;
    localparam logic [1:0] C_MODE_SRL = 2'b01;
    localparam logic [1:0] C_MODE_SRA = 2'b10;
    localparam logic [1:0] C_MODE_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_shifter_step.sv
// ============================================================================
// Module  : shift_step
// Brief   : Combinational single step of 0..STEP bits in SLL/SRL/SRA/ROR.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_step
    import seq_shifter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STEP       = 4
) (
    input  logic [DATA_WIDTH-1:0]     in,
    input  logic [$clog2(STEP):0]     k,
    input  logic [1:0]                mode,
    output logic [DATA_WIDTH-1:0]     out
);

    logic [DATA_WIDTH-1:0] w_ror;

    // With k=0 the left shift is by DATA_WIDTH and vanishes, leaving the operand intact.
    assign w_ror = (in >> k) | (in << (DATA_WIDTH - int'(k)));

    always_comb begin
        out = in;
        case (mode)
            C_MODE_SLL: out = in << k;
            C_MODE_SRL: out = in >> k;
            C_MODE_SRA: out = $unsigned($signed(in) >>> k);
            C_MODE_ROR: out = w_ror;
            default:    out = in;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seq_shifter.sv
// ============================================================================
// Module  : seq_shifter
// Brief   : Multi-cycle variable shifter, at most STEP bits per clock, start/done.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5,
    parameter int STEP        = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    input  logic [DATA_WIDTH-1:0]  in,
    output logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  out
);

    localparam int C_KW = $clog2(STEP) + 1;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DATA_WIDTH-1:0]  r_out;
    logic [DATA_WIDTH-1:0]  w_out_nxt;
    logic [SHAMT_WIDTH-1:0] r_rem;
    logic [SHAMT_WIDTH-1:0] w_rem_nxt;
    logic [1:0]             r_mode;
    logic [1:0]             w_mode_nxt;
    logic [C_KW-1:0]        w_k;
    logic [SHAMT_WIDTH-1:0] w_k_ext;
    logic [DATA_WIDTH-1:0]  w_step_out;

    // k = min(remaining, STEP); k never exceeds remaining so the counter cannot wrap.
    always_comb begin
        if (int'(r_rem) >= STEP) begin
            w_k = C_KW'(STEP);
        end else begin
            w_k = C_KW'(r_rem);
        end
        w_k_ext = SHAMT_WIDTH'(w_k);
    end

    shift_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .STEP       (STEP)
    ) u_step (
        .in   (r_out),
        .k    (w_k),
        .mode (r_mode),
        .out  (w_step_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
            r_rem   <= '0;
            r_mode  <= C_MODE_SLL;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_rem   <= w_rem_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_rem_nxt   = r_rem;
        w_mode_nxt  = r_mode;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_out_nxt   = in;
                    w_rem_nxt   = shamt;
                    w_mode_nxt  = mode;
                    w_state_nxt = (shamt != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                w_out_nxt = w_step_out;
                w_rem_nxt = r_rem - w_k_ext;
                if (r_rem == w_k_ext) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ready = (r_state == ST_IDLE);
    assign busy  = (r_state == ST_SHIFT) || (r_state == ST_DONE);
    assign done  = (r_state == ST_DONE);
    assign out   = r_out;

endmodule

`default_nettype wire

// File: tb/tb_seq_shifter.sv
// ============================================================================
// Module  : tb_seq_shifter
// Brief   : Directed self-checking bench for seq_shifter (DATA_WIDTH=32, STEP=4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_shifter;
    import seq_shifter_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [4:0]  shamt;
    logic [31:0] in;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] out;

    int n_tests;
    int n_fail;

    seq_shifter #(
        .DATA_WIDTH  (32),
        .SHAMT_WIDTH (5),
        .STEP        (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .shamt (shamt),
        .in    (in),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Accepts one request, then counts edges and busy cycles up to the DONE pulse.
    task automatic do_op(input string tag, input logic [1:0] m, input logic [4:0] s,
                         input logic [31:0] d, input logic [31:0] exp, input int exp_edges);
        int edges;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1; mode = m; shamt = s; in = d;
        @(negedge clk);
        start = 1'b0; mode = 2'b00; shamt = 5'd0; in = 32'h0;
        edges    = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && edges < 64) begin
            @(negedge clk);
            edges++;
            if (busy) busy_cnt++;
        end
        check({tag, "_out"}, out, exp);
        check({tag, "_edges"}, 32'(edges), 32'(exp_edges));
        check({tag, "_busy"}, 32'(busy_cnt), 32'(exp_edges));
        @(negedge clk);
        check({tag, "_ready_after"}, {31'd0, ready}, 32'd1);
        check({tag, "_done_cleared"}, {31'd0, done}, 32'd0);
        check({tag, "_out_hold"}, out, exp);
    endtask

    initial begin
        int done_cnt;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; start = 1'b0; mode = 2'b00; shamt = 5'd0; in = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_out",   out,             32'h0);
        check("rst_ready", {31'd0, ready},  32'd1);
        check("rst_busy",  {31'd0, busy},   32'd0);
        check("rst_done",  {31'd0, done},   32'd0);
        rst = 1'b0;

        do_op("sll2",     C_MODE_SLL, 5'd2,  32'h0000_0001, 32'h0000_0004, 2);
        do_op("sra31",    C_MODE_SRA, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 9);
        do_op("srl31",    C_MODE_SRL, 5'd31, 32'h8000_0000, 32'h0000_0001, 9);
        do_op("ror4",     C_MODE_ROR, 5'd4,  32'h0000_0001, 32'h1000_0000, 2);
        do_op("ror5",     C_MODE_ROR, 5'd5,  32'h0000_001F, 32'hF800_0000, 3);
        do_op("sra0",     C_MODE_SRA, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
        do_op("sra9",     C_MODE_SRA, 5'd9,  32'h8000_0000, 32'hFFC0_0000, 4);
        do_op("sra7pos",  C_MODE_SRA, 5'd7,  32'h4000_0000, 32'h0080_0000, 3);
        do_op("ror31",    C_MODE_ROR, 5'd31, 32'h1234_5678, 32'h2468_ACF0, 9);
        do_op("sll31",    C_MODE_SLL, 5'd31, 32'hDEAD_BEEF, 32'h8000_0000, 9);

        // START while busy and while DONE must both be ignored.
        @(negedge clk);
        start = 1'b1; mode = C_MODE_SLL; shamt = 5'd8; in = 32'h0000_0001;
        @(negedge clk);
        mode = C_MODE_ROR; shamt = 5'd3; in = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8 && !done; i++) @(negedge clk);
        check("busy_prot_done", {31'd0, done}, 32'd1);
        check("busy_prot_out",  out, 32'h0000_0100);
        start = 1'b1; in = 32'h0;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done_ignored", {31'd0, ready}, 32'd1);
        check("start_in_done_out",     out, 32'h0000_0100);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("busy_prot_no_2nd_done", 32'(done_cnt), 32'd0);

        // Reset two edges into a long SRL aborts with no DONE pulse.
        @(negedge clk);
        start = 1'b1; mode = C_MODE_SRL; shamt = 5'd20; in = 32'hF000_0000;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_out",   out,            32'h0);
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_busy",  {31'd0, busy},  32'd0);
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        do_op("srl20_after", C_MODE_SRL, 5'd20, 32'hF000_0000, 32'h0000_0F00, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
